// File: rtl/pkg_cpu.sv
// CPU bus encodings shared by the spcpu core and its peripherals.
package pkg_cpu;

    typedef enum logic {
        cpu_data_acc_sz_8  = 1'b0,
        cpu_data_acc_sz_16 = 1'b1
    } cpu_data_acc_sz_t;

endpackage

// File: rtl/spcpu_mem_ctrl_pkg.sv
// Types and byte-lane helper for the spcpu memory controller.
package pkg_mem_ctrl;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        CAPT  = 2'd3
    } mem_ctrl_state_t;

    typedef logic mem_ctrl_phase_t;

    localparam int MEM_CTRL_MAX_WAIT_STATES = 15;

    typedef struct packed {
        logic [1:0]  byte_en;
        logic [15:0] wdata;
    } lane_drive_t;

    // Split phase 0 writes the low data byte into lane 1, phase 1 the high byte into lane 0.
    function automatic lane_drive_t lane_drive(input logic            is16,
                                               input logic            lane,
                                               input logic            split,
                                               input mem_ctrl_phase_t phase,
                                               input logic [15:0]     wdata);
        lane_drive_t d;
        d.byte_en = 2'b11;
        d.wdata   = wdata;
        if (!is16) begin
            d.byte_en = lane ? 2'b10 : 2'b01;
            d.wdata   = {wdata[7:0], wdata[7:0]};
        end else if (split) begin
            if (phase == 1'b0) begin
                d.byte_en = 2'b10;
                d.wdata   = {wdata[7:0], wdata[7:0]};
            end else begin
                d.byte_en = 2'b01;
                d.wdata   = {wdata[15:8], wdata[15:8]};
            end
        end else begin
            d.byte_en = 2'b11;
            d.wdata   = wdata;
        end
        return d;
    endfunction

endpackage

// File: rtl/spcpu_mem_ctrl_wait_counter.sv
// Wait-state down-counter: load with WAIT_STATES, count down, done on the last wait cycle.
module mem_ctrl_wait_counter #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [CW-1:0] count_r;

    // Remaining wait cycles of the current phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= CW'(WAIT_STATES);
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == CW'(1));

endmodule

// File: rtl/spcpu_mem_ctrl.sv
// spcpu bus to 16-bit byte-enabled synchronous RAM: wait states, lane steering, unaligned split.
module spcpu_mem_ctrl
    import pkg_cpu::*;
    import pkg_mem_ctrl::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int WAIT_STATES  = 0,
    parameter int UNALIGNED_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  data_acc_sz,
    input  logic                  data_inout_we,
    input  logic [15:0]           write_data_in,
    output logic [15:0]           read_data_out,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  misalign,
    output logic [ADDR_WIDTH-2:0] ram_addr,
    output logic [15:0]           ram_wdata,
    output logic [1:0]            ram_byte_en,
    output logic                  ram_we,
    input  logic [15:0]           ram_rdata
);

    localparam int              WORD_WIDTH  = ADDR_WIDTH - 1;
    localparam mem_ctrl_state_t ENTRY_STATE = (WAIT_STATES > 0) ? WAIT : ISSUE;

    mem_ctrl_state_t       state_r, next_state_s;
    mem_ctrl_phase_t       phase_r, phase_next_s;
    logic [ADDR_WIDTH-1:0] addr_r, src_addr_s;
    logic                  is16_r, we_r, split_r, mis_r;
    logic [15:0]           wdata_r, src_wdata_s;
    logic                  src_is16_s, src_we_s, src_split_s;
    logic                  accept_s, final_s, req_is16_s, req_split_s, req_mis_s;
    logic                  wait_load_s, wait_dec_s, wait_done_s;
    logic [7:0]            lo_byte_r;
    logic [15:0]           rdata_hold_r, assembled_s;
    logic [WORD_WIDTH-1:0] word_s;
    lane_drive_t           drive_s;
    logic                  data_ready_r, busy_r, misalign_r, ram_we_r;
    logic [WORD_WIDTH-1:0] ram_addr_r;
    logic [15:0]           ram_wdata_r;
    logic [1:0]            ram_byte_en_r;

    assign req_is16_s  = (data_acc_sz == cpu_data_acc_sz_16);
    assign req_split_s = (UNALIGNED_EN != 0) && req_is16_s && addr_in[0];
    assign req_mis_s   = (UNALIGNED_EN == 0) && req_is16_s && addr_in[0];
    assign final_s     = !split_r || (phase_r == 1'b1);
    assign wait_load_s = (next_state_s == WAIT) && (state_r != WAIT);
    assign wait_dec_s  = (state_r == WAIT);

    mem_ctrl_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load_s),
        .dec   (wait_dec_s),
        .done  (wait_done_s)
    );

    // Next state, phase advance and request acceptance.
    always_comb begin
        next_state_s = state_r;
        phase_next_s = phase_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_rdwr) begin
                    accept_s     = 1'b1;
                    phase_next_s = 1'b0;
                    next_state_s = ENTRY_STATE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_done_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            ISSUE: next_state_s = CAPT;
            CAPT: begin
                if (!final_s) begin
                    phase_next_s = 1'b1;
                    next_state_s = ENTRY_STATE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // RAM drive is computed from the live bus in IDLE so ISSUE outputs can be registered.
    always_comb begin
        if (state_r == IDLE) begin
            src_addr_s  = addr_in;
            src_is16_s  = req_is16_s;
            src_we_s    = data_inout_we;
            src_wdata_s = write_data_in;
            src_split_s = req_split_s;
        end else begin
            src_addr_s  = addr_r;
            src_is16_s  = is16_r;
            src_we_s    = we_r;
            src_wdata_s = wdata_r;
            src_split_s = split_r;
        end
        drive_s = lane_drive(src_is16_s, src_addr_s[0], src_split_s, phase_next_s, src_wdata_s);
        word_s  = src_addr_s[ADDR_WIDTH-1:1] + WORD_WIDTH'(phase_next_s);
    end

    // Read result assembly from the RAM word returned during CAPT.
    always_comb begin
        if (!is16_r) begin
            assembled_s = {8'h00, (addr_r[0] ? ram_rdata[15:8] : ram_rdata[7:0])};
        end else if (split_r) begin
            assembled_s = {ram_rdata[7:0], lo_byte_r};
        end else begin
            assembled_s = ram_rdata;
        end
    end

    // State, latched request and captured read bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            phase_r      <= 1'b0;
            addr_r       <= '0;
            is16_r       <= 1'b0;
            we_r         <= 1'b0;
            wdata_r      <= 16'h0000;
            split_r      <= 1'b0;
            mis_r        <= 1'b0;
            lo_byte_r    <= 8'h00;
            rdata_hold_r <= 16'h0000;
        end else begin
            state_r <= next_state_s;
            phase_r <= phase_next_s;
            if (accept_s) begin
                addr_r  <= addr_in;
                is16_r  <= req_is16_s;
                we_r    <= data_inout_we;
                wdata_r <= write_data_in;
                split_r <= req_split_s;
                mis_r   <= req_mis_s;
            end
            if ((state_r == CAPT) && !final_s) begin
                lo_byte_r <= ram_rdata[15:8];
            end
            if ((state_r == CAPT) && final_s && !we_r) begin
                rdata_hold_r <= assembled_s;
            end
        end
    end

    // Registered bus and RAM outputs, aligned with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_ready_r  <= 1'b0;
            busy_r        <= 1'b0;
            misalign_r    <= 1'b0;
            ram_addr_r    <= '0;
            ram_wdata_r   <= 16'h0000;
            ram_byte_en_r <= 2'b00;
            ram_we_r      <= 1'b0;
        end else begin
            data_ready_r <= (state_r == ISSUE) && final_s;
            busy_r       <= (next_state_s != IDLE);
            misalign_r   <= (state_r == ISSUE) && final_s && mis_r;
            if (next_state_s == ISSUE) begin
                ram_addr_r    <= word_s;
                ram_wdata_r   <= drive_s.wdata;
                ram_byte_en_r <= drive_s.byte_en;
                ram_we_r      <= src_we_s;
            end else begin
                ram_addr_r    <= '0;
                ram_wdata_r   <= 16'h0000;
                ram_byte_en_r <= 2'b00;
                ram_we_r      <= 1'b0;
            end
        end
    end

    // RAM data arrives only during CAPT, so the completing read is forwarded straight through.
    assign read_data_out = ((state_r == CAPT) && final_s && !we_r) ? assembled_s : rdata_hold_r;
    assign data_ready    = data_ready_r;
    assign busy          = busy_r;
    assign misalign      = misalign_r;
    assign ram_addr      = ram_addr_r;
    assign ram_wdata     = ram_wdata_r;
    assign ram_byte_en   = ram_byte_en_r;
    assign ram_we        = ram_we_r;

endmodule

// File: tb/tb_spcpu_mem_ctrl.sv
// Bench for spcpu_mem_ctrl: three configurations, directed cases then random traffic vs a byte-level model.
module tb_spcpu_mem_ctrl;

    logic        clk;
    logic        rst_n   [3];
    logic        req     [3];
    logic [15:0] addr    [3];
    logic        sz      [3];
    logic        we      [3];
    logic [15:0] wd      [3];
    logic [15:0] rdo     [3];
    logic        dr      [3];
    logic        bsy     [3];
    logic        mis     [3];
    logic [14:0] raddr   [3];
    logic [15:0] rwd     [3];
    logic [1:0]  rbe     [3];
    logic        rwe     [3];
    logic        poke_en [3];
    logic [14:0] poke_a  [3];
    logic [15:0] poke_d  [3];

    logic [7:0]  refb    [3][65536];
    logic [15:0] last_rd [3];
    logic [33:0] iss_q   [$];
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] mem [32768];
        logic [15:0] rdata;

        always @(posedge clk) begin
            if (poke_en[g]) begin
                mem[poke_a[g]] <= poke_d[g];
            end else if (rwe[g]) begin
                mem[raddr[g]] <= {(rbe[g][1] ? rwd[g][15:8] : mem[raddr[g]][15:8]),
                                  (rbe[g][0] ? rwd[g][7:0]  : mem[raddr[g]][7:0])};
            end
            rdata <= mem[raddr[g]];
        end

        spcpu_mem_ctrl #(
            .ADDR_WIDTH   (16),
            .WAIT_STATES  ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .UNALIGNED_EN ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk           (clk),
            .reset         (rst_n[g]),
            .req_rdwr      (req[g]),
            .addr_in       (addr[g]),
            .data_acc_sz   (sz[g]),
            .data_inout_we (we[g]),
            .write_data_in (wd[g]),
            .read_data_out (rdo[g]),
            .data_ready    (dr[g]),
            .busy          (bsy[g]),
            .misalign      (mis[g]),
            .ram_addr      (raddr[g]),
            .ram_wdata     (rwd[g]),
            .ram_byte_en   (rbe[g]),
            .ram_we        (rwe[g]),
            .ram_rdata     (rdata)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int i, input logic [14:0] w, input logic [15:0] d);
        poke_en[i] = 1'b1;
        poke_a[i]  = w;
        poke_d[i]  = d;
        @(posedge clk);
        #1;
        poke_en[i] = 1'b0;
        refb[i][{w, 1'b0}] = d[7:0];
        refb[i][{w, 1'b1}] = d[15:8];
    endtask

    task automatic outputs_zero(input int i, input string tag);
        chk(tag, {11'd0, rdo[i], dr[i], bsy[i], mis[i], raddr[i], rwd[i], rbe[i], rwe[i]}, 64'd0);
    endtask

    // Behavioural model: byte memory, expected result, latency, misalign flag and RAM cycle count.
    task automatic ref_access(input int i, input logic [15:0] a, input logic s16, input logic w,
                              input logic [15:0] d, output logic [15:0] erd, output int elat,
                              output logic em, output int niss);
        int          ws;
        logic        odd16, split;
        logic [15:0] base, hi, val;
        ws    = (i == 0) ? 0 : ((i == 1) ? 2 : 3);
        odd16 = s16 && a[0];
        split = odd16 && (i != 2);
        em    = odd16 && (i == 2);
        base  = em ? (a & 16'hFFFE) : a;
        hi    = base + 16'd1;
        if (!s16) begin
            if (w) refb[i][a] = d[7:0];
            val = {8'h00, refb[i][a]};
        end else begin
            if (w) begin
                refb[i][base] = d[7:0];
                refb[i][hi]   = d[15:8];
            end
            val = {refb[i][hi], refb[i][base]};
        end
        if (!w) last_rd[i] = val;
        erd  = last_rd[i];
        elat = split ? (4 + 2 * ws) : (2 + ws);
        niss = split ? 2 : 1;
    endtask

    task automatic access(input int i, input logic [15:0] a, input logic s16, input logic w,
                          input logic [15:0] d, output logic [15:0] rd, output int lat, output logic m);
        iss_q.delete();
        lat     = -1;
        rd      = 16'hxxxx;
        m       = 1'bx;
        req[i]  = 1'b1;
        addr[i] = a;
        sz[i]   = s16;
        we[i]   = w;
        wd[i]   = d;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                addr[i] = 16'($urandom);
                wd[i]   = 16'($urandom);
            end
            if (rbe[i] != 2'b00) iss_q.push_back({rwe[i], raddr[i], rbe[i], rwd[i]});
            if (dr[i]) begin
                lat    = k + 1;
                rd     = rdo[i];
                m      = mis[i];
                req[i] = 1'b0;
                break;
            end
        end
        req[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int i, input logic [15:0] a, input logic s16, input logic w,
                       input logic [15:0] d, output logic [15:0] rd, output int lat, output logic m);
        logic [15:0] erd;
        int          elat, niss;
        logic        em;
        ref_access(i, a, s16, w, d, erd, elat, em, niss);
        access(i, a, s16, w, d, rd, lat, m);
        chk($sformatf("rdata i%0d a%h", i, a), 64'(rd), 64'(erd));
        chk($sformatf("latency i%0d a%h", i, a), 64'(lat), 64'(elat));
        chk($sformatf("misalign i%0d a%h", i, a), 64'(m), 64'(em));
        chk($sformatf("ram_cycles i%0d a%h", i, a), 64'(iss_q.size()), 64'(niss));
        chk($sformatf("idle_after i%0d", i), 64'(bsy[i]), 64'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        logic        m;
        logic        we_seen;
        int          i;
        logic [15:0] a;
        checks = 0;
        errors = 0;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b1; req[k] = 1'b0; addr[k] = 16'h0000; sz[k] = 1'b0;
            we[k] = 1'b0; wd[k] = 16'h0000; poke_en[k] = 1'b0; poke_a[k] = 15'd0;
            poke_d[k] = 16'h0000; last_rd[k] = 16'h0000;
        end
        #2;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) outputs_zero(k, $sformatf("reset_outputs i%0d", k));
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 32; w++) poke(k, 15'(w), 16'($urandom));
            poke(k, 15'h7FFF, 16'($urandom));
        end

        // 1: aligned 16-bit read, W=0
        poke(0, 15'h0008, 16'hBEEF);
        poke(0, 15'h0009, 16'h1234);
        run(0, 16'h0010, 1'b1, 1'b0, 16'h0000, rd, lat, m);
        chk("t1_rdata", 64'(rd), 64'hBEEF);
        chk("t1_latency", 64'(lat), 64'd2);
        // 2: odd byte read
        run(0, 16'h0011, 1'b0, 1'b0, 16'h0000, rd, lat, m);
        chk("t2_rdata", 64'(rd), 64'h00BE);
        chk("t2_byte_en", 64'(iss_q[0][17:16]), 64'h2);
        // 3: unaligned split read
        run(0, 16'h0011, 1'b1, 1'b0, 16'h0000, rd, lat, m);
        chk("t3_rdata", 64'(rd), 64'h34BE);
        chk("t3_latency", 64'(lat), 64'd4);
        chk("t3_issue0", 64'(iss_q[0][32:16]), 64'({15'h0008, 2'b10}));
        chk("t3_issue1", 64'(iss_q[1][32:16]), 64'({15'h0009, 2'b01}));
        // 4: W=2 split write wrapping from 0xFFFF to word 0
        run(1, 16'hFFFF, 1'b1, 1'b1, 16'hCAFE, rd, lat, m);
        chk("t4_latency", 64'(lat), 64'd8);
        chk("t4_issue0", 64'({iss_q[0][33:16], iss_q[0][15:8]}), 64'({1'b1, 15'h7FFF, 2'b10, 8'hFE}));
        chk("t4_issue1", 64'({iss_q[1][33:16], iss_q[1][7:0]}), 64'({1'b1, 15'h0000, 2'b01, 8'hCA}));
        // 5: unaligned forced aligned, W=3
        poke(2, 15'h0008, 16'hBEEF);
        run(2, 16'h0011, 1'b1, 1'b0, 16'h0000, rd, lat, m);
        chk("t5_rdata", 64'(rd), 64'hBEEF);
        chk("t5_misalign", 64'(m), 64'd1);
        chk("t5_issue", 64'(iss_q[0][32:16]), 64'({15'h0008, 2'b11}));
        // 6: reset during WAIT of a write abandons it
        req[2] = 1'b1; addr[2] = 16'h0020; sz[2] = 1'b1; we[2] = 1'b1; wd[2] = 16'h1111;
        @(posedge clk);
        #1;
        we_seen = rwe[2];
        @(posedge clk);
        #1;
        we_seen = we_seen | rwe[2];
        rst_n[2] = 1'b0;
        #1;
        outputs_zero(2, "t6_reset_outputs");
        req[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            we_seen = we_seen | rwe[2];
        end
        rst_n[2] = 1'b1;
        last_rd[2] = 16'h0000;
        @(posedge clk);
        #1;
        chk("t6_no_ram_we", 64'(we_seen), 64'd0);
        run(2, 16'h0013, 1'b0, 1'b1, 16'h00A5, rd, lat, m);
        chk("t6_latency", 64'(lat), 64'd5);
        chk("t6_issue", 64'(iss_q[0][17:0]), 64'({2'b10, 16'hA5A5}));
        run(2, 16'h0020, 1'b1, 1'b0, 16'h0000, rd, lat, m);

        // Random traffic against the byte model
        for (int n = 0; n < 150; n++) begin
            i = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'hFFFE;
            else a = 16'($urandom_range(0, 62));
            run(i, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), rd, lat, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spcpu_mem_ctrl.md
Name: spcpu_mem_ctrl

Overview:
Parametrised memory controller between the spcpu bus (req_rdwr / data_ready handshake, 8/16-bit access size) and a single-port synchronous 16-bit RAM with byte enables. It replaces the fixed-latency, aligned-only testbench memory path. It adds:
- programmable wait states;
- byte-lane steering;
- little-endian unaligned 16-bit accesses, split into two RAM cycles;
- a misalignment flag.

It is used both in simulation benches and in the FPGA top level.

Parameters:
ADDR_WIDTH, 16, CPU byte-address width; RAM word address is ADDR_WIDTH-1 bits.
WAIT_STATES, 0, idle cycles inserted before every RAM issue (0..15).
UNALIGNED_EN, 1, 1 = split unaligned 16-bit accesses; 0 = force aligned and flag.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_rdwr  in  1  CPU access request (level)
addr_in  in  ADDR_WIDTH  CPU byte address
data_acc_sz  in  1  pkg_cpu::cpu_data_acc_sz_8 / cpu_data_acc_sz_16
data_inout_we  in  1  1 = write, 0 = read
write_data_in  in  16  CPU write data; 8-bit writes use [7:0]
read_data_out  out  16  read result; 8-bit reads zero-extended
data_ready  out  1  one-cycle completion pulse
busy  out  1  high whenever state != IDLE
misalign  out  1  pulses with data_ready when an unaligned 16-bit access was forced aligned
ram_addr  out  ADDR_WIDTH-1  RAM word address
ram_wdata  out  16  RAM write data
ram_byte_en  out  2  [0] = even byte / bits 7:0, [1] = odd byte / bits 15:8
ram_we  out  1  RAM write strobe
ram_rdata  in  16  RAM read data, valid one cycle after issue

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0: read_data_out, data_ready, busy, misalign, ram_addr, ram_wdata, ram_byte_en, ram_we. Reset mid-access abandons the access; no partial second-phase write occurs after reset.
- States:
  - IDLE -> WAIT or ISSUE.
  - WAIT -> ISSUE.
  - ISSUE -> CAPT.
  - CAPT -> IDLE, or WAIT/ISSUE for phase 2.
- IDLE: on req_rdwr=1 at edge N, latch addr, size, we and wdata; set phase=0. Go to WAIT if WAIT_STATES>0, else ISSUE.
- WAIT: counter loaded with WAIT_STATES, decrements; leave for ISSUE when it reaches 1.
- ISSUE: one cycle driving ram_addr / ram_byte_en / ram_wdata / ram_we. ram_we is asserted only in ISSUE and only for writes; ram_byte_en is 0 outside ISSUE.
- CAPT:
  - Read data is taken from ram_rdata.
  - For the final phase, data_ready=1 for exactly this cycle and read_data_out is updated; it holds until the next completion.
  - For writes, read_data_out is unchanged.
- Lane mapping (little-endian, byte a is in word a>>1, lane a[0]):
  - 8-bit: byte_en = one-hot of a[0]; wdata = {wbyte, wbyte}; result = {8'h00, selected lane}.
  - 16-bit aligned: byte_en=2'b11, single phase.
  - 16-bit unaligned, UNALIGNED_EN=1:
    - Phase 0: word a>>1, lane 1, carries low data byte.
    - Phase 1: word (a>>1)+1, lane 0, carries high data byte.
    - Phase 1 incurs WAIT_STATES again.
    - Word address wraps modulo 2^(ADDR_WIDTH-1): address 0xFFFF continues at word 0.
  - 16-bit unaligned, UNALIGNED_EN=0: a[0] is ignored, access runs as aligned, misalign pulses with data_ready.
- Latency, with W = WAIT_STATES:
  - Aligned or 8-bit: data_ready at N+2+W.
  - Split access: data_ready at N+4+2W.
- Back-to-back: IDLE follows CAPT. If req_rdwr is still high, a new access is accepted one cycle after data_ready. The CPU drops req_rdwr on data_ready.
- Inputs are ignored while busy. Changing addr_in mid-access has no effect.

Decomposition:
- pkg_cpu (existing): cpu_data_acc_sz_8/16.
- New package pkg_mem_ctrl: mem_ctrl_state_t enum {IDLE, WAIT, ISSUE, CAPT}, the phase typedef, and the max-wait-state constant.
- One sub-module: mem_ctrl_wait_counter. It provides load, decrement and done, with width $clog2(WAIT_STATES+1).

Test Plan:
1. W=0, RAM word 0x0008=0xBEEF; 16-bit read at 0x0010 accepted at N -> data_ready at N+2, read_data_out=0xBEEF, misalign=0.
2. Same RAM; 8-bit read at 0x0011 -> read_data_out=0x00BE at N+2, ram_byte_en=2'b10 during ISSUE.
3. W=0, word 0x0009=0x1234; 16-bit read at 0x0011 -> two ISSUE cycles (word 0x0008 be 10, word 0x0009 be 01), data_ready at N+4, read_data_out=0x34BE.
4. W=2; 16-bit write 0xCAFE at 0xFFFF -> ISSUE word 0x7FFF be 10 wdata[15:8]=0xFE, then ISSUE word 0x0000 be 01 wdata[7:0]=0xCA, data_ready at N+8.
5. UNALIGNED_EN=0; 16-bit read at 0x0011 -> single access to word 0x0008 be 11, read_data_out=0xBEEF, misalign=1 together with data_ready.
6. W=3; assert reset low during WAIT of a write -> outputs 0 immediately, ram_we never asserted. After release, 8-bit write 0xA5 at 0x0013 -> be 10, wdata 0xA5A5, data_ready at N+5.
